// File: rtl/sr_drv_pkg.sv
// Shared definitions for the SR flip-flop excitation driver.
// Contents: FSM state encoding, counter widths, per-bit excitation function.
// No ports; imported by sr_excite and sr_excite_driver.
package sr_drv_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_CHECK  = 2'd3
  } state_t;

  // Phase counter covers PULSE_CYC/SETTLE_CYC up to 15; retry counter covers 0..7.
  localparam int CNT_W   = 4;
  localparam int RETRY_W = 3;

  // Returns {s, r} for one bit. Only a bit that differs from its target is excited,
  // and S and R can never both be 1 because they depend on opposite values of tgt.
  function automatic logic [1:0] excite_bit(input logic tgt, input logic q);
    excite_bit = {tgt & ~q, ~tgt & q};
  endfunction

endpackage

// File: rtl/sr_excite.sv
// Combinational per-bit S/R excitation and match check for a WIDTH-bit SR bank.
// Ports: tgt/q/qnot in (WIDTH), s/r out (WIDTH), pass out (1).
// pass requires Q equal to target and every Qnot the inverse of its Q.
module sr_excite
  import sr_drv_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] tgt,
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] qnot,
  output logic [WIDTH-1:0] s,
  output logic [WIDTH-1:0] r,
  output logic             pass
);

  always_comb begin
    s = '0;
    r = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {s[i], r[i]} = excite_bit(tgt[i], q[i]);
    end
    // A bit with q == qnot is invalid feedback and must count as a mismatch.
    pass = (q == tgt) && (qnot == ~q);
  end

endmodule

// File: rtl/sr_excite_driver.sv
// Drives a bank of gated SR flip-flops toward a requested Q pattern, with retries.
// Ports: clk, rst_n; req_valid/req_data/req_ready handshake; s_out/r_out to bank;
//        q_in/qnot_in feedback; busy level, done/err one-cycle pulses.
module sr_excite_driver
  import sr_drv_pkg::*;
#(
  parameter int WIDTH      = 4,
  parameter int PULSE_CYC  = 2,
  parameter int SETTLE_CYC = 1,
  parameter int MAX_RETRY  = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             req_valid,
  input  logic [WIDTH-1:0] req_data,
  output logic             req_ready,
  output logic [WIDTH-1:0] s_out,
  output logic [WIDTH-1:0] r_out,
  input  logic [WIDTH-1:0] q_in,
  input  logic [WIDTH-1:0] qnot_in,
  output logic             busy,
  output logic             done,
  output logic             err
);

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [RETRY_W-1:0] retry, retry_nxt;
  logic [WIDTH-1:0]   tgt, tgt_nxt;
  logic [WIDTH-1:0]   s_nxt, r_nxt;
  logic               done_nxt, err_nxt;

  logic [WIDTH-1:0]   exc_s, exc_r;
  logic               pass;

  sr_excite #(.WIDTH(WIDTH)) u_excite (
    .tgt  (tgt),
    .q    (q_in),
    .qnot (qnot_in),
    .s    (exc_s),
    .r    (exc_r),
    .pass (pass)
  );

  assign req_ready = (state == ST_IDLE);
  assign busy      = (state != ST_IDLE);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
      cnt   <= '0;
      retry <= '0;
      tgt   <= '0;
      s_out <= '0;
      r_out <= '0;
      done  <= 1'b0;
      err   <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      retry <= retry_nxt;
      tgt   <= tgt_nxt;
      s_out <= s_nxt;
      r_out <= r_nxt;
      done  <= done_nxt;
      err   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    retry_nxt = retry;
    tgt_nxt   = tgt;
    s_nxt     = s_out;
    r_nxt     = r_out;
    done_nxt  = 1'b0;
    err_nxt   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          tgt_nxt   = req_data;
          retry_nxt = '0;
          cnt_nxt   = '0;
          state_nxt = ST_DRIVE;
        end
      end

      // cnt==0 is the entry cycle: excitation is computed from the live Q and
      // registered at its end, so the bank sees it for cnt=1..PULSE_CYC.
      ST_DRIVE: begin
        if (cnt == '0) begin
          s_nxt   = exc_s;
          r_nxt   = exc_r;
          cnt_nxt = cnt + CNT_W'(1);
        end else if (cnt == CNT_W'(PULSE_CYC)) begin
          s_nxt     = '0;
          r_nxt     = '0;
          cnt_nxt   = '0;
          state_nxt = ST_SETTLE;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_SETTLE: begin
        if (cnt == CNT_W'(SETTLE_CYC - 1)) begin
          cnt_nxt   = '0;
          state_nxt = ST_CHECK;
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      ST_CHECK: begin
        if (pass) begin
          done_nxt  = 1'b1;
          state_nxt = ST_IDLE;
        end else if (retry < RETRY_W'(MAX_RETRY)) begin
          retry_nxt = retry + RETRY_W'(1);
          cnt_nxt   = '0;
          state_nxt = ST_DRIVE;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ST_IDLE;
        end
      end

      default: state_nxt = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_sr_excite_driver.sv
// Closed-loop bench: one behavioural SR flip-flop per bit driven by s_out/r_out.
// Directed scenarios with hand-computed expectations; S&R overlap watched every cycle.
// Prints one TB_RESULT summary line.
module tb_sr_excite_driver;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       req_valid = 1'b0;
  logic [3:0] req_data = 4'b0000;
  logic       req_ready;
  logic [3:0] s_out, r_out;
  logic [3:0] q_bank = 4'b0000;
  logic [3:0] stuck0 = 4'b0000;
  logic       busy, done, err;

  int checks = 0;
  int failures = 0;

  // Per-cycle trace after an accept; index n = state after accept edge + n.
  logic [3:0] s_tr [0:19];
  logic [3:0] r_tr [0:19];
  logic [3:0] q_tr [0:19];
  logic       done_tr [0:19];
  logic       err_tr [0:19];
  logic       busy_tr [0:19];
  logic       rdy_tr [0:19];
  int         done_at, err_at, done_cnt;

  sr_excite_driver dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_data  (req_data),
    .req_ready (req_ready),
    .s_out     (s_out),
    .r_out     (r_out),
    .q_in      (q_bank),
    .qnot_in   (~q_bank),
    .busy      (busy),
    .done      (done),
    .err       (err)
  );

  always #5 clk = ~clk;

  // Behavioural SR bank; a stuck bit ignores S.
  always @(posedge clk) begin
    for (int i = 0; i < 4; i++) begin
      if (stuck0[i])                q_bank[i] <= 1'b0;
      else if (s_out[i] && !r_out[i]) q_bank[i] <= 1'b1;
      else if (r_out[i] && !s_out[i]) q_bank[i] <= 1'b0;
    end
  end

  always @(negedge clk) begin
    checks++;
    if ((s_out & r_out) !== 4'b0000) begin
      failures++;
      $display("FAIL sr_overlap s_out=%b r_out=%b required s_out&r_out=0000", s_out, r_out);
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

  task automatic send(input logic [3:0] d);
    req_valid = 1'b1;
    req_data  = d;
    @(posedge clk);
    #1 req_valid = 1'b0;
  endtask

  task automatic capture(input int n_max);
    done_at = -1; err_at = -1; done_cnt = 0;
    for (int n = 0; n <= n_max; n++) begin
      @(negedge clk);
      s_tr[n] = s_out; r_tr[n] = r_out; q_tr[n] = q_bank;
      done_tr[n] = done; err_tr[n] = err; busy_tr[n] = busy; rdy_tr[n] = req_ready;
      if (done) begin done_cnt++; if (done_at < 0) done_at = n; end
      if (err && err_at < 0) err_at = n;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({req_ready, busy, done, err, s_out, r_out} !== {4'b1000, 8'h00}) begin
      failures++;
      $display("FAIL reset_state ready=%b busy=%b done=%b err=%b s=%b r=%b required 1 0 0 0 0000 0000",
               req_ready, busy, done, err, s_out, r_out);
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_set_from_zero();
    send(4'b1010);
    capture(6);
    checks++;
    if (s_tr[0] !== 4'b0000 || r_tr[0] !== 4'b0000 || busy_tr[0] !== 1'b1) begin
      failures++;
      $display("FAIL t1_entry s=%b r=%b busy=%b required 0000 0000 1", s_tr[0], r_tr[0], busy_tr[0]);
    end
    for (int n = 1; n <= 4; n++) begin
      logic [3:0] exp_s;
      exp_s = (n <= 2) ? 4'b1010 : 4'b0000;
      checks++;
      if (s_tr[n] !== exp_s || r_tr[n] !== 4'b0000) begin
        failures++;
        $display("FAIL t1_excite n=%0d s=%b r=%b required %b 0000", n, s_tr[n], r_tr[n], exp_s);
      end
    end
    checks++;
    if (done_at !== 5 || done_cnt !== 1 || err_at !== -1) begin
      failures++;
      $display("FAIL t1_done done_at=%0d done_cnt=%0d err_at=%0d required 5 1 -1", done_at, done_cnt, err_at);
    end
    checks++;
    if (q_tr[5] !== 4'b1010 || rdy_tr[5] !== 1'b1 || busy_tr[5] !== 1'b0) begin
      failures++;
      $display("FAIL t1_final q=%b ready=%b busy=%b required 1010 1 0", q_tr[5], rdy_tr[5], busy_tr[5]);
    end
  endtask

  task automatic test_mixed();
    send(4'b0110);
    capture(6);
    checks++;
    if (s_tr[1] !== 4'b0100 || r_tr[1] !== 4'b1000 || s_tr[2] !== 4'b0100 || r_tr[2] !== 4'b1000) begin
      failures++;
      $display("FAIL t2_excite s=%b/%b r=%b/%b required 0100 1000", s_tr[1], s_tr[2], r_tr[1], r_tr[2]);
    end
    checks++;
    if (s_tr[3] !== 4'b0000 || r_tr[3] !== 4'b0000) begin
      failures++;
      $display("FAIL t2_settle s=%b r=%b required 0000 0000", s_tr[3], r_tr[3]);
    end
    checks++;
    if (done_at !== 5 || q_tr[5] !== 4'b0110) begin
      failures++;
      $display("FAIL t2_done done_at=%0d q=%b required 5 0110", done_at, q_tr[5]);
    end
  endtask

  task automatic test_same_target();
    int nonzero;
    nonzero = 0;
    send(4'b0110);
    capture(6);
    for (int n = 0; n <= 6; n++) if (s_tr[n] !== 4'b0000 || r_tr[n] !== 4'b0000) nonzero++;
    checks++;
    if (nonzero !== 0) begin
      failures++;
      $display("FAIL t3_zero_excite nonzero_cycles=%0d required 0", nonzero);
    end
    checks++;
    if (done_at !== 5 || busy_tr[4] !== 1'b1 || q_tr[5] !== 4'b0110) begin
      failures++;
      $display("FAIL t3_done done_at=%0d busy4=%b q=%b required 5 1 0110", done_at, busy_tr[4], q_tr[5]);
    end
  endtask

  task automatic test_retry_err();
    int pulses, s_cycles;
    pulses = 0; s_cycles = 0;
    stuck0 = 4'b0001;
    send(4'b0001);
    capture(17);
    for (int n = 0; n <= 17; n++) begin
      if (s_tr[n][0]) s_cycles++;
      if (s_tr[n][0] && (n == 0 || !s_tr[n-1][0])) pulses++;
    end
    checks++;
    if (pulses !== 3 || s_cycles !== 6) begin
      failures++;
      $display("FAIL t4_pulses pulses=%0d s_cycles=%0d required 3 6", pulses, s_cycles);
    end
    checks++;
    if (r_tr[1] !== 4'b0110 || s_tr[6] !== 4'b0001 || r_tr[6] !== 4'b0000) begin
      failures++;
      $display("FAIL t4_excite r1=%b s6=%b r6=%b required 0110 0001 0000", r_tr[1], s_tr[6], r_tr[6]);
    end
    checks++;
    if (err_at !== 15 || done_at !== -1 || err_tr[16] !== 1'b0) begin
      failures++;
      $display("FAIL t4_err err_at=%0d done_at=%0d err16=%b required 15 -1 0", err_at, done_at, err_tr[16]);
    end
    stuck0 = 4'b0000;
  endtask

  task automatic test_reset_mid();
    int stray;
    stray = 0;
    send(4'b0101);
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (s_out !== 4'b0101 || busy !== 1'b1) begin
      failures++;
      $display("FAIL t5_drive s=%b busy=%b required 0101 1", s_out, busy);
    end
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (s_out !== 4'b0000 || r_out !== 4'b0000 || busy !== 1'b0 || req_ready !== 1'b1 || done !== 1'b0 || err !== 1'b0) begin
      failures++;
      $display("FAIL t5_abort s=%b r=%b busy=%b ready=%b done=%b err=%b required 0000 0000 0 1 0 0",
               s_out, r_out, busy, req_ready, done, err);
    end
    rst_n = 1'b1;
    for (int n = 0; n < 6; n++) begin
      @(negedge clk);
      if (done || err || busy) stray++;
    end
    checks++;
    if (stray !== 0) begin
      failures++;
      $display("FAIL t5_no_pulse stray_cycles=%0d required 0", stray);
    end
    send(4'b1111);
    capture(6);
    checks++;
    if (s_tr[1] !== 4'b1010 || done_at !== 5 || q_tr[5] !== 4'b1111) begin
      failures++;
      $display("FAIL t5_after s1=%b done_at=%0d q=%b required 1010 5 1111", s_tr[1], done_at, q_tr[5]);
    end
  endtask

  task automatic test_back_to_back();
    logic [3:0] noise [0:4];
    int early_rdy;
    logic [3:0] r1_first;
    logic       done5;
    noise[0] = 4'b0011; noise[1] = 4'b1100; noise[2] = 4'b0101;
    noise[3] = 4'b1010; noise[4] = 4'b0111;
    early_rdy = 0;
    r1_first = 4'b0000;
    done5 = 1'b0;
    req_valid = 1'b1;
    req_data  = 4'b0000;
    @(posedge clk);
    for (int n = 0; n <= 5; n++) begin
      @(negedge clk);
      if (n < 5 && req_ready) early_rdy++;
      if (n == 1) r1_first = r_out;
      if (n == 5) done5 = done;
      req_data = (n < 5) ? noise[n] : 4'b1001;
    end
    checks++;
    if (early_rdy !== 0 || r1_first !== 4'b1111 || done5 !== 1'b1 || q_bank !== 4'b0000) begin
      failures++;
      $display("FAIL t6_first early_rdy=%0d r1=%b done5=%b q=%b required 0 1111 1 0000",
               early_rdy, r1_first, done5, q_bank);
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    capture(6);
    checks++;
    if (s_tr[1] !== 4'b1001 || r_tr[1] !== 4'b0000 || done_at !== 5 || q_tr[5] !== 4'b1001) begin
      failures++;
      $display("FAIL t6_second s1=%b r1=%b done_at=%0d q=%b required 1001 0000 5 1001",
               s_tr[1], r_tr[1], done_at, q_tr[5]);
    end
  endtask

  initial begin
    test_reset();
    test_set_from_zero();
    test_mixed();
    test_same_target();
    test_retry_err();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
